booth_mult_bcd_display: RTL and testbench

- Sequential radix-2 Booth multiplier for two signed 16-bit operands.
- The registered 16-bit result is shown as a sign flag plus five 7-segment digits, via combinational binary-to-BCD (double-dabble) and BCD-to-7-segment decoders.
- Sits in the calculator datapath: the operand registers feed it, and its outputs drive the board displays.

---
 rtl/booth_mult_bcd_display_if.sv | 28 ++
 rtl/booth_mult_bcd_display.sv | 144 ++++++++++++++
 tb/tb_booth_mult_bcd_display.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_bcd_display_if.sv
// rtl/booth_mult_bcd_display_if.sv - operand/start and product/display bundle for the Booth multiplier
interface booth_mult_bcd_display_if;
  logic        start;
  logic [15:0] mc;
  logic [15:0] mp;
  logic        ready;
  logic [31:0] prod;
  logic [15:0] result_16b;
  logic        ovf;
  logic        sign;
  logic [6:0]  ones;
  logic [6:0]  tens;
  logic [6:0]  hundreds;
  logic [6:0]  thousand;
  logic [6:0]  ten_thousand;

  modport master (
    output start, mc, mp,
    input  ready, prod, result_16b, ovf, sign,
    input  ones, tens, hundreds, thousand, ten_thousand
  );

  modport slave (
    input  start, mc, mp,
    output ready, prod, result_16b, ovf, sign,
    output ones, tens, hundreds, thousand, ten_thousand
  );
endinterface

// File: rtl/booth_mult_bcd_display.sv
// rtl/booth_mult_bcd_display.sv - sequential radix-2 Booth multiplier with BCD 7-segment readout
module booth_mult_bcd_display #(
  parameter int DATA_W         = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  booth_mult_bcd_display_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state;
  logic [DATA_W-1:0]   m_reg;
  logic [DATA_W:0]     a_reg;      // one guard bit so A - (-32768) cannot wrap
  logic [DATA_W-1:0]   q_reg;
  logic                q_1;
  logic [CNT_W-1:0]    count;
  logic [2*DATA_W-1:0] prod_reg;

  logic [DATA_W:0]     m_ext;
  logic [DATA_W:0]     booth_sum;
  logic [DATA_W:0]     a_shift;
  logic [DATA_W-1:0]   q_shift;

  logic [DATA_W-1:0]   res;
  logic                ovf;
  logic [DATA_W:0]     mag;
  logic [19:0]         bcd;

  // One Booth step: add/subtract M on {Q0,q_1}, then arithmetic shift of {A,Q}
  always_comb begin
    m_ext     = {m_reg[DATA_W-1], m_reg};
    booth_sum = a_reg;
    case ({q_reg[0], q_1})
      2'b01:   booth_sum = a_reg + m_ext;
      2'b10:   booth_sum = a_reg - m_ext;
      default: booth_sum = a_reg;
    endcase
    a_shift = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
    q_shift = {booth_sum[0], q_reg[DATA_W-1:1]};
  end

  // Control FSM and datapath registers; prod is only written on the last iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      m_reg    <= '0;
      a_reg    <= '0;
      q_reg    <= '0;
      q_1      <= 1'b0;
      count    <= '0;
      prod_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            m_reg <= bus.mc;
            a_reg <= '0;
            q_reg <= bus.mp;
            q_1   <= 1'b0;
            count <= CNT_W'(DATA_W);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_reg <= a_shift;
          q_reg <= q_shift;
          q_1   <= q_reg[0];
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            prod_reg <= {a_shift[DATA_W-1:0], q_shift};
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result views and overflow: upper bits must be a pure sign extension of bit 15
  always_comb begin
    res = prod_reg[DATA_W-1:0];
    ovf = ~(&prod_reg[2*DATA_W-1:DATA_W-1]) & (|prod_reg[2*DATA_W-1:DATA_W-1]);
    if (res[DATA_W-1])
      mag = (~{1'b1, res}) + {{DATA_W{1'b0}}, 1'b1};
    else
      mag = {1'b0, res};
  end

  // Double-dabble: 17-bit magnitude into five BCD digits
  always_comb begin
    bcd = '0;
    for (int i = DATA_W; i >= 0; i--) begin
      for (int d = 0; d < 5; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5)
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[18:0], mag[i]};
    end
  end

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit, input logic dash);
    logic [6:0] p;
    if (dash) begin
      p = 7'h3F;
    end else begin
      case (digit)
        4'd0:    p = 7'h40;
        4'd1:    p = 7'h79;
        4'd2:    p = 7'h24;
        4'd3:    p = 7'h30;
        4'd4:    p = 7'h19;
        4'd5:    p = 7'h12;
        4'd6:    p = 7'h02;
        4'd7:    p = 7'h78;
        4'd8:    p = 7'h00;
        4'd9:    p = 7'h10;
        default: p = 7'h7F;
      endcase
    end
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction

  // Output mapping; overflow replaces every digit with a dash
  always_comb begin
    bus.ready        = (state == ST_DONE);
    bus.prod         = prod_reg;
    bus.result_16b   = res;
    bus.ovf          = ovf;
    bus.sign         = res[DATA_W-1];
    bus.ones         = seg_pattern(bcd[3:0],   ovf);
    bus.tens         = seg_pattern(bcd[7:4],   ovf);
    bus.hundreds     = seg_pattern(bcd[11:8],  ovf);
    bus.thousand     = seg_pattern(bcd[15:12], ovf);
    bus.ten_thousand = seg_pattern(bcd[19:16], ovf);
  end

endmodule

// File: tb/tb_booth_mult_bcd_display.sv
// tb/tb_booth_mult_bcd_display.sv - directed self-checking bench for booth_mult_bcd_display
module tb_booth_mult_bcd_display;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_mult_bcd_display_if bus ();

  booth_mult_bcd_display #(.DATA_W(16), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] d4, input logic [6:0] d3,
                              input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
    check({tag, ".ten_thousand"}, {25'd0, bus.ten_thousand}, {25'd0, d4});
    check({tag, ".thousand"},     {25'd0, bus.thousand},     {25'd0, d3});
    check({tag, ".hundreds"},     {25'd0, bus.hundreds},     {25'd0, d2});
    check({tag, ".tens"},         {25'd0, bus.tens},         {25'd0, d1});
    check({tag, ".ones"},         {25'd0, bus.ones},         {25'd0, d0});
  endtask

  task automatic check_result(input string tag, input logic [31:0] p, input logic s, input logic o);
    check({tag, ".prod"},       bus.prod,                 p);
    check({tag, ".result_16b"}, {16'd0, bus.result_16b},  {16'd0, p[15:0]});
    check({tag, ".sign"},       {31'd0, bus.sign},        {31'd0, s});
    check({tag, ".ovf"},        {31'd0, bus.ovf},         {31'd0, o});
  endtask

  // Launch one multiply, check 16-edge latency and single-cycle ready; returns at the ready cycle + 1
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.mc    = a;
    bus.mp    = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, ".latency"}, lat, 16);
    @(negedge clk);
    check({tag, ".ready_width"}, {31'd0, bus.ready}, 32'd0);
  endtask

  initial begin
    int pulses;
    int lat;
    int gap;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.mc    = '0;
    bus.mp    = '0;
    #2 rst = 1'b1;
    #20;

    check_result("reset", 32'h0, 1'b0, 1'b0);
    check("reset.ready", {31'd0, bus.ready}, 32'd0);
    check_digits("reset", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    @(negedge clk);
    rst = 1'b0;

    // 7 * -50 = -350
    do_op("neg350", 16'd7, 16'hFFCE);
    check_result("neg350", 32'hFFFFFEA2, 1'b1, 1'b0);
    check_digits("neg350", 7'h40, 7'h40, 7'h30, 7'h12, 7'h40);

    // Reset asserted mid-BUSY clears prod and suppresses ready
    @(negedge clk);
    bus.mc    = 16'd181;
    bus.mp    = 16'd181;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.prod", bus.prod, 32'h0);
    check("abort.ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) pulses++;
    end
    check("abort.no_ready", pulses, 0);
    check("abort.prod_held", bus.prod, 32'h0);

    // -32768 * 1
    do_op("min", 16'h8000, 16'd1);
    check_result("min", 32'hFFFF8000, 1'b1, 1'b0);
    check_digits("min", 7'h30, 7'h24, 7'h78, 7'h02, 7'h00);

    // 181 * 181 = 32761
    do_op("sq181", 16'd181, 16'd181);
    check_result("sq181", 32'd32761, 1'b0, 1'b0);
    check_digits("sq181", 7'h30, 7'h24, 7'h78, 7'h02, 7'h79);

    // 300 * 200 = 60000 overflows
    do_op("ovf60k", 16'd300, 16'd200);
    check_result("ovf60k", 32'h0000EA60, 1'b1, 1'b1);
    check_digits("ovf60k", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // -32768 * -32768
    do_op("minsq", 16'h8000, 16'h8000);
    check_result("minsq", 32'h40000000, 1'b0, 1'b1);
    check_digits("minsq", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // 128 * 256 = +32768, just out of range
    do_op("pos32768", 16'd128, 16'd256);
    check_result("pos32768", 32'h00008000, 1'b1, 1'b1);

    // 99 * 101 = 9999 and 1 * -4 exercise the remaining digit patterns
    do_op("n9999", 16'd99, 16'd101);
    check_result("n9999", 32'd9999, 1'b0, 1'b0);
    check_digits("n9999", 7'h40, 7'h10, 7'h10, 7'h10, 7'h10);
    do_op("neg4", 16'd1, 16'hFFFC);
    check_result("neg4", 32'hFFFFFFFC, 1'b1, 1'b0);
    check_digits("neg4", 7'h40, 7'h40, 7'h40, 7'h40, 7'h19);
    do_op("nn12", 16'hFFFD, 16'hFFFC);
    check_result("nn12", 32'd12, 1'b0, 1'b0);
    check_digits("nn12", 7'h40, 7'h40, 7'h40, 7'h79, 7'h24);

    // Start and operand changes while BUSY are ignored
    @(negedge clk);
    bus.mc    = 16'd181;
    bus.mp    = 16'd181;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5) begin
        bus.mc    = 16'd300;
        bus.mp    = 16'd200;
        bus.start = 1'b1;
      end
      if (k == 6) bus.start = 1'b0;
      if (bus.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("ignore.latency", lat, 16);
    check("ignore.prod", bus.prod, 32'd32761);

    // Start held high: back-to-back operations every 18 cycles
    repeat (4) @(negedge clk);
    bus.mc    = 16'd7;
    bus.mp    = 16'hFFCE;
    bus.start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("hold.first_seen", {31'd0, (lat != 0)}, 32'd1);
    gap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        gap = k;
        break;
      end
    end
    check("hold.period", gap, 18);
    check("hold.prod", bus.prod, 32'hFFFFFEA2);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
